// File: rtl/branch_ctrl.sv
// Fetch-side branch decoder: turns the ROM word at PC into a next-PC redirect,
// and owns the Z/C condition flags and the CALL/RET return-address stack.
module branch_ctrl #(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned CNT_W       = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [ADDR_W-1:0] PC,
    input  logic [DATA_W-1:0] INSTR,
    input  logic              ALU_Z,
    input  logic              ALU_C,
    input  logic              FLAG_WE,
    output logic [6:0]        TYPE,
    output logic              B1_OUT,
    output logic [ADDR_W-1:0] PC_VAL,
    output logic [CNT_W-1:0]  STK_CNT,
    output logic              STK_ERR,
    output logic              ILLEGAL
);

    localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_JZ   = 5'b10001;
    localparam logic [4:0] OP_JNZ  = 5'b10010;
    localparam logic [4:0] OP_JC   = 5'b10011;
    localparam logic [4:0] OP_JNC  = 5'b10100;
    localparam logic [4:0] OP_CALL = 5'b10101;
    localparam logic [4:0] OP_RET  = 5'b10110;

    logic [4:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] pc_inc;

    logic              z_q;
    logic              c_q;
    logic              stk_err_q;
    logic              illegal_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic              stack_full;
    logic              stack_empty;
    logic [PTR_W-1:0]  push_idx;
    logic [PTR_W-1:0]  top_idx;
    logic [ADDR_W-1:0] top_val;

    logic              is_call;
    logic              is_ret;
    logic              is_illegal;

    assign op     = INSTR[DATA_W-1 -: 5];
    assign addr   = INSTR[ADDR_W-1:0];
    assign pc_inc = PC + ADDR_W'(1);

    assign stack_full  = (cnt_q == CNT_W'(STACK_DEPTH));
    assign stack_empty = (cnt_q == '0);
    assign push_idx    = PTR_W'(cnt_q);
    assign top_idx     = PTR_W'(cnt_q - CNT_W'(1));
    // An empty stack returns to address 0 rather than a stale entry.
    assign top_val     = stack_empty ? '0 : stack_q[top_idx];

    always_comb begin
        TYPE       = '0;
        B1_OUT     = 1'b0;
        PC_VAL     = '0;
        is_call    = 1'b0;
        is_ret     = 1'b0;
        is_illegal = 1'b0;
        if (!op[4]) begin
            TYPE = {3'b000, op[3:0]};
        end else begin
            unique case (op)
                OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC, OP_CALL, OP_RET: begin
                    TYPE   = {1'b1, 3'b000, op[2:0]};
                    PC_VAL = addr;
                end
                default: is_illegal = 1'b1;
            endcase
            unique case (op)
                OP_JMP:  B1_OUT = 1'b1;
                OP_JZ:   B1_OUT = z_q;
                OP_JNZ:  B1_OUT = !z_q;
                OP_JC:   B1_OUT = c_q;
                OP_JNC:  B1_OUT = !c_q;
                OP_CALL: begin
                    B1_OUT  = 1'b1;
                    is_call = 1'b1;
                end
                OP_RET: begin
                    B1_OUT = 1'b1;
                    PC_VAL = top_val;
                    is_ret = 1'b1;
                end
                default: B1_OUT = 1'b0;
            endcase
        end
    end

    // Flags update at the edge, so a branch in the same cycle sees the old value.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            stk_err_q <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (FLAG_WE) begin
                z_q <= ALU_Z;
                c_q <= ALU_C;
            end
            if (is_illegal) begin
                illegal_q <= 1'b1;
            end
            if (is_call) begin
                if (stack_full) begin
                    stk_err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (is_ret) begin
                if (stack_empty) begin
                    stk_err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    // Stack contents need no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (is_call && !stack_full) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign STK_CNT = cnt_q;
    assign STK_ERR = stk_err_q;
    assign ILLEGAL = illegal_q;

endmodule
